// File: rtl/mult_pkg.sv
// Shared types and sizes for the radix-4 Booth multiplier.
// Imported by the recoder and the multiplier top.
package mult_pkg;

  localparam int ITER  = 16;
  localparam int OP_W  = 32;
  localparam int ACC_W = 34;
  localparam int P_W   = 67;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mult_state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_sel_t;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth window decode and partial-term generation.
// Negative terms come out inverted with a carry-in of one.
module booth_recoder
  import mult_pkg::*;
(
  input  logic [2:0]       win_i,
  input  logic [OP_W-1:0]  m_i,
  output booth_sel_t       sel_o,
  output logic [ACC_W-1:0] term_o,
  output logic             cin_o
);

  logic [ACC_W-1:0] m1;
  logic [ACC_W-1:0] m2;

  assign m1 = {{2{m_i[OP_W-1]}}, m_i};
  assign m2 = {m_i[OP_W-1], m_i, 1'b0};

  always_comb begin
    sel_o = ZERO;
    case (win_i)
      3'b000: sel_o = ZERO;
      3'b001: sel_o = POS1;
      3'b010: sel_o = POS1;
      3'b011: sel_o = POS2;
      3'b100: sel_o = NEG2;
      3'b101: sel_o = NEG1;
      3'b110: sel_o = NEG1;
      3'b111: sel_o = ZERO;
      default: sel_o = ZERO;
    endcase
  end

  always_comb begin
    term_o = '0;
    cin_o  = 1'b0;
    unique case (1'b1)
      (sel_o == POS1): term_o = m1;
      (sel_o == POS2): term_o = m2;
      (sel_o == NEG1): begin
        term_o = ~m1;
        cin_o  = 1'b1;
      end
      (sel_o == NEG2): begin
        term_o = ~m2;
        cin_o  = 1'b1;
      end
      default: begin
        term_o = '0;
        cin_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed 32x32 radix-4 Booth multiplier, 16 iterations.
// Returns product[31:0] and flags products that overflow 32 bits.
module booth_mult
  import mult_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ctrl_MULT,
  input  logic [OP_W-1:0] data_operandA,
  input  logic [OP_W-1:0] data_operandB,
  output logic [OP_W-1:0] data_result,
  output logic            data_exception,
  output logic            data_resultRDY
);

  mult_state_t     state_q, state_d;
  logic [OP_W-1:0] m_q, m_d;
  logic [P_W-1:0]  p_q, p_d;
  logic [3:0]      cnt_q, cnt_d;

  booth_sel_t       sel;
  logic [ACC_W-1:0] term;
  logic             cin;
  logic [ACC_W-1:0] sum;
  logic [P_W-1:0]   p_sh;
  logic [OP_W:0]    hi;

  booth_recoder u_rec (
    .win_i  (p_q[2:0]),
    .m_i    (m_q),
    .sel_o  (sel),
    .term_o (term),
    .cin_o  (cin)
  );

  assign sum  = p_q[P_W-1:OP_W+1] + term
              + {{(ACC_W-1){1'b0}}, cin};
  assign p_sh = {{2{sum[ACC_W-1]}}, sum, p_q[OP_W:2]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: ;
      BUSY: begin
        p_d   = p_sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER - 1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A start in any state wins and abandons the running operation
    if (ctrl_MULT) begin
      m_d     = data_operandA;
      p_d     = {{ACC_W{1'b0}}, data_operandB, 1'b0};
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // product[63:31] = {U[31:0], L[31]}
  assign hi             = {p_q[OP_W+OP_W:OP_W+1], p_q[OP_W]};
  assign data_result    = p_q[OP_W:1];
  assign data_exception = (|hi) && !(&hi);
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: doc/booth_mult.md
# booth_mult

Sequential signed 32×32 multiplier using radix-4 (modified) Booth recoding, 16 iterations per operation. It is the multiplicative counterpart of the iterative divider and sits beside it in the execute stage. The pipeline starts it with a one-cycle pulse and stalls until `data_resultRDY` pulses. It returns the low 32 bits of the 64-bit signed product and flags products that do not fit in 32 bits.

## Interface
- `ITER`, 16: Booth iterations (32 multiplier bits / 2 per iteration).
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ctrl_MULT` input 1: start pulse; operands are sampled on the same edge.
- `data_operandA` input 32: multiplicand, two's complement.
- `data_operandB` input 32: multiplier, two's complement.
- `data_result` output 32: product[31:0], valid while `data_resultRDY` is high and held afterward.
- `data_exception` output 1: overflow flag, valid with `data_result`.
- `data_resultRDY` output 1: single-cycle completion pulse.

## Operation
- States: IDLE, BUSY, DONE.
- Datapath registers:
  - M: 32-bit multiplicand.
  - P: 67-bit product register = {U[33:0], L[31:0], q_m1}. U is a sign-extended 34-bit accumulator; q_m1 is the Booth guard bit.
  - cnt: 4-bit iteration counter.
- Start (any state, `ctrl_MULT` = 1 at the edge):
  - M ← A.
  - U ← 0, L ← B, q_m1 ← 0, cnt ← 0.
  - State → BUSY. A start during BUSY or DONE aborts the current operation; no RDY is produced for the aborted operation.
- BUSY edge:
  - Recode {L[1], L[0], q_m1}: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - U ← U + term, with M sign-extended to 34 bits.
  - Arithmetic shift right of the whole P by 2.
  - cnt ← cnt + 1. When cnt = 15, state → DONE.
- DONE: `data_resultRDY` = 1. Next edge → IDLE unless `ctrl_MULT` = 1.
- Result:
  - product[63:0] = {U[31:0], L}.
  - `data_result` = L.
  - `data_exception` = 1 iff product[63:31] is not all-zeros and not all-ones.
- Outputs are combinational from registers. `data_result` and `data_exception` hold their last values until the next start.
- Reset:
  - Asynchronous. State → IDLE; P, M and cnt → 0.
  - All outputs read 0 while `reset_n` is low and after release.
  - A reset during BUSY discards the operation; no RDY pulse follows.

## Timing
- Start sampled at edge E0. BUSY edges are E1 through E16. `data_resultRDY` is high for exactly the cycle between E16 and E17.
- Latency: 16 cycles from the start edge to RDY visible; one RDY cycle per completed operation.
- `ctrl_MULT` held high for several cycles restarts on every edge. Callers pulse it for exactly one cycle.
- Operands need only be stable at E0; they are don't-care afterward.
- Back-to-back: a start in the DONE cycle is legal. RDY for the first operation is still seen in that cycle.

## Structure
- Shared package `mult_pkg`:
  - State enum `mult_state_t` (IDLE, BUSY, DONE).
  - `ITER`, `ACC_W` = 34, `P_W` = 67.
  - Booth select encoding `booth_sel_t` (ZERO, POS1, POS2, NEG1, NEG2).
- One sub-module `booth_recoder`: a combinational map from the 3-bit window to `booth_sel_t`, plus generation of the 34-bit term (0, ±M, ±2M) via invert and carry-in.
- The adder is a plain 34-bit add with carry-in for the negation.

## Test plan
- 7 × 6:
  - Start at E0 → RDY high exactly at E16–E17.
  - Result 0x0000002A, exception 0.
- Signs:
  - −3 × 5 → 0xFFFFFFF1, exception 0.
  - −1 × −1 → 0x00000001.
  - 0x7FFFFFFF × 1 → 0x7FFFFFFF.
- Overflow:
  - 0x80000000 × −1 → result 0x80000000, exception 1.
  - 0x00010000 × 0x00010000 → result 0x00000000, exception 1.
  - 0x80000000 × 1 → exception 0.
- Restart: start 3 × 4, then start 9 × 9 five cycles later.
  - Exactly one RDY pulse, 16 cycles after the second start.
  - Result 0x00000051.
- Reset during BUSY (cycle 8):
  - RDY stays low; outputs read 0.
  - A following −1 × −1 completes normally with result 1.
- Back-to-back: 2 × 3 with a start of 4 × 5 in its DONE cycle.
  - Result 6 visible with RDY in the DONE cycle.
  - 20 appears 16 cycles later.
- Random: 1000 random signed pairs checked against a 64-bit reference model for both result and exception.
